// File: rtl/fpu_defs.sv
// Shared FPU conversion-slice definitions: rounding-mode encoding, the
// int-to-float sequencer states and its default format constants.
package fpu_defs;

  localparam logic [1:0] C_RM_NEAREST  = 2'h0;
  localparam logic [1:0] C_RM_TRUNC    = 2'h1;
  localparam logic [1:0] C_RM_PLUSINF  = 2'h2;
  localparam logic [1:0] C_RM_MINUSINF = 2'h3;

  localparam int C_ITOF_WIDTH    = 32;
  localparam int C_ITOF_EXP      = 8;
  localparam int C_ITOF_MANT     = 23;
  localparam int C_ITOF_BIAS     = 127;
  localparam int C_ITOF_EXP_INIT = C_ITOF_BIAS + C_ITOF_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } itof_state_t;

endpackage

// File: rtl/fpu_itof_round.sv
// Rounds a normalised (MSB set) integer magnitude to a packed single-precision
// value under the selected rounding mode and reports inexactness.
module fpu_itof_round
  import fpu_defs::*;
#(
  parameter int C_WIDTH = C_ITOF_WIDTH,
  parameter int C_EXP   = C_ITOF_EXP,
  parameter int C_MANT  = C_ITOF_MANT
) (
  input  logic                    sign,
  input  logic [C_EXP-1:0]        exponent,
  input  logic [C_WIDTH-1:0]      mag,
  input  logic [1:0]              rm,
  output logic [C_EXP+C_MANT:0]   result,
  output logic                    inexact
);

  logic [C_MANT-1:0] mant_s;
  logic              guard_s;
  logic              sticky_s;
  logic              round_up_s;
  logic [C_MANT:0]   mant_sum_s;
  logic [C_EXP-1:0]  exp_out_s;
  logic [C_MANT-1:0] mant_out_s;
  logic              unused_msb_s;

  // The MSB is the hidden leading one and is not stored.
  assign unused_msb_s = mag[C_WIDTH-1];

  // Extract mantissa, guard and sticky, then apply the rounding decision.
  always_comb begin
    mant_s   = mag[C_WIDTH-2 -: C_MANT];
    guard_s  = mag[C_WIDTH-2-C_MANT];
    sticky_s = |mag[C_WIDTH-3-C_MANT:0];
    inexact  = guard_s | sticky_s;
    case (rm)
      C_RM_NEAREST:  round_up_s = guard_s & (sticky_s | mant_s[0]);
      C_RM_TRUNC:    round_up_s = 1'b0;
      C_RM_PLUSINF:  round_up_s = inexact & ~sign;
      C_RM_MINUSINF: round_up_s = inexact & sign;
      default:       round_up_s = 1'b0;
    endcase
    mant_sum_s = {1'b0, mant_s} + {{C_MANT{1'b0}}, round_up_s};
    // Carry out of the mantissa renormalises to the next binade.
    if (mant_sum_s[C_MANT]) begin
      exp_out_s  = exponent + C_EXP'(1);
      mant_out_s = {C_MANT{1'b0}};
    end else begin
      exp_out_s  = exponent;
      mant_out_s = mant_sum_s[C_MANT-1:0];
    end
    result = {sign, exp_out_s, mant_out_s};
  end

endmodule

// File: rtl/fpu_itof_seq.sv
// Sequential integer-to-single-precision converter with valid/ready on both sides.
// Define FPU_ITOF_LZC_EN for single-cycle normalisation via a leading-zero count.
module fpu_itof_seq
  import fpu_defs::*;
#(
  parameter int C_WIDTH = C_ITOF_WIDTH,
  parameter int C_EXP   = C_ITOF_EXP,
  parameter int C_MANT  = C_ITOF_MANT,
  parameter int C_BIAS  = C_ITOF_BIAS
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Valid_SI,
  output logic                  Ready_SO,
  input  logic [C_WIDTH-1:0]    Operand_a_DI,
  input  logic                  Signed_SI,
  input  logic [1:0]            RM_SI,
  input  logic                  Flush_SI,
  output logic                  Valid_SO,
  input  logic                  Ready_SI,
  output logic [C_EXP+C_MANT:0] Result_DO,
  output logic                  Zero_SO,
  output logic                  IX_SO
);

  localparam logic [C_EXP-1:0] C_EXP_INIT = C_EXP'(C_BIAS + C_WIDTH - 1);

  itof_state_t            state_r, state_next_s;
  logic [C_WIDTH-1:0]     op_r;
  logic                   signed_r;
  logic [1:0]             rm_r;
  logic                   sign_r;
  logic [C_WIDTH-1:0]     mag_r;
  logic [C_EXP-1:0]       exp_r;
  logic [C_EXP+C_MANT:0]  result_r;
  logic                   zero_r;
  logic                   ix_r;
  logic                   valid_r;
  logic                   ready_s;
  logic                   accept_s;
  logic                   abs_sign_s;
  logic [C_WIDTH-1:0]     abs_mag_s;
  logic [C_EXP+C_MANT:0]  round_result_s;
  logic                   round_ix_s;

`ifdef FPU_ITOF_LZC_EN
  localparam int C_LZW = $clog2(C_WIDTH);
  logic [C_LZW-1:0] lz_r;

  function automatic logic [C_LZW-1:0] lzc(input logic [C_WIDTH-1:0] v);
    logic found;
    lzc   = {C_LZW{1'b0}};
    found = 1'b0;
    for (int i = C_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc   = lzc + C_LZW'(1);
      end
    end
  endfunction
`endif

  // State register.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Sign and magnitude of the latched operand; -2^31 maps to 0x80000000.
  always_comb begin
    abs_sign_s = signed_r & op_r[C_WIDTH-1];
    if (abs_sign_s) abs_mag_s = -op_r;
    else            abs_mag_s = op_r;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next_s = state_r;
    if (Flush_SI) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_next_s = accept_s ? ABS : IDLE;
        ABS:     state_next_s = (abs_mag_s == {C_WIDTH{1'b0}}) ? DONE : NORM;
`ifdef FPU_ITOF_LZC_EN
        NORM:    state_next_s = ROUND;
`else
        NORM:    state_next_s = mag_r[C_WIDTH-1] ? ROUND : NORM;
`endif
        ROUND:   state_next_s = DONE;
        DONE:    state_next_s = Ready_SI ? IDLE : DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Handshake outputs.
  always_comb begin
    ready_s  = (state_r == IDLE) & ~Flush_SI & ~Rst_RI;
    accept_s = Valid_SI & ready_s;
  end

  fpu_itof_round #(
    .C_WIDTH (C_WIDTH),
    .C_EXP   (C_EXP),
    .C_MANT  (C_MANT)
  ) u_round (
    .sign     (sign_r),
    .exponent (exp_r),
    .mag      (mag_r),
    .rm       (rm_r),
    .result   (round_result_s),
    .inexact  (round_ix_s)
  );

  // Datapath and registered result; outputs clear whenever the FSM returns to IDLE.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      op_r     <= {C_WIDTH{1'b0}};
      signed_r <= 1'b0;
      rm_r     <= 2'b00;
      sign_r   <= 1'b0;
      mag_r    <= {C_WIDTH{1'b0}};
      exp_r    <= {C_EXP{1'b0}};
      result_r <= {(C_EXP+C_MANT+1){1'b0}};
      zero_r   <= 1'b0;
      ix_r     <= 1'b0;
      valid_r  <= 1'b0;
`ifdef FPU_ITOF_LZC_EN
      lz_r     <= {C_LZW{1'b0}};
`endif
    end else if (Flush_SI) begin
      result_r <= {(C_EXP+C_MANT+1){1'b0}};
      zero_r   <= 1'b0;
      ix_r     <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r     <= Operand_a_DI;
            signed_r <= Signed_SI;
            rm_r     <= RM_SI;
          end
        end
        ABS: begin
          sign_r <= abs_sign_s;
          mag_r  <= abs_mag_s;
          exp_r  <= C_EXP_INIT;
`ifdef FPU_ITOF_LZC_EN
          lz_r   <= lzc(abs_mag_s);
`endif
          if (abs_mag_s == {C_WIDTH{1'b0}}) begin
            result_r <= {(C_EXP+C_MANT+1){1'b0}};
            zero_r   <= 1'b1;
            ix_r     <= 1'b0;
            valid_r  <= 1'b1;
          end
        end
        NORM: begin
`ifdef FPU_ITOF_LZC_EN
          mag_r <= mag_r << lz_r;
          exp_r <= exp_r - {{(C_EXP-C_LZW){1'b0}}, lz_r};
`else
          if (!mag_r[C_WIDTH-1]) begin
            mag_r <= mag_r << 1;
            exp_r <= exp_r - C_EXP'(1);
          end
`endif
        end
        ROUND: begin
          result_r <= round_result_s;
          zero_r   <= 1'b0;
          ix_r     <= round_ix_s;
          valid_r  <= 1'b1;
        end
        DONE: begin
          if (Ready_SI) begin
            result_r <= {(C_EXP+C_MANT+1){1'b0}};
            zero_r   <= 1'b0;
            ix_r     <= 1'b0;
            valid_r  <= 1'b0;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign Ready_SO  = ready_s;
  assign Valid_SO  = valid_r;
  assign Result_DO = result_r;
  assign Zero_SO   = zero_r;
  assign IX_SO     = ix_r;

endmodule

// File: doc/fpu_itof_seq.md
Name: fpu_itof_seq

Overview:
- Multi-cycle converter from a 32-bit signed or unsigned integer to an IEEE-754 single-precision result, with the selected rounding mode applied.
- Companion to the combinational float-to-integer converter.
- Sits in the FPU conversion slice behind a valid/ready handshake on both sides.
- Normalises iteratively, one bit per cycle, so area stays small at the cost of variable latency.

Parameters:
- C_WIDTH, 32, integer operand width.
- C_EXP, 8, exponent width of the result.
- C_MANT, 23, stored mantissa width of the result.
- C_BIAS, 127, exponent bias.

Ports:
- Clk_CI  in  1  clock
- Rst_RI  in  1  asynchronous reset, active-high
- Valid_SI  in  1  input operand valid
- Ready_SO  out  1  block can accept an operand
- Operand_a_DI  in  C_WIDTH  integer operand
- Signed_SI  in  1  1 = two's-complement operand, 0 = unsigned
- RM_SI  in  2  rounding mode (package C_RM_* encoding)
- Flush_SI  in  1  abort the operation in flight
- Valid_SO  out  1  result valid
- Ready_SI  in  1  downstream accepts the result
- Result_DO  out  C_EXP+C_MANT+1  float result
- Zero_SO  out  1  result is +0
- IX_SO  out  1  result is inexact

Behaviour:
- Reset: state IDLE; Valid_SO, Result_DO, Zero_SO, IX_SO all 0; internal registers 0.
- Ready_SO = (state==IDLE) & ~Flush_SI & ~Rst_RI.
- Accept: occurs on an edge where Valid_SI & Ready_SO. Operand, Signed_SI and RM_SI are latched; IDLE->ABS.
- ABS state:
  - sign = Signed_SI & op[MSB].
  - mag = sign ? two's-complement negation of op : op. -2^31 negates to 0x80000000 as an unsigned value.
  - exp = C_BIAS + C_WIDTH - 1 (158).
  - mag==0 -> DONE with Result 0, Zero_SO 1, IX_SO 0. Otherwise -> NORM.
- NORM state:
  - If mag[MSB]==0: shift mag left 1, decrement exp, stay in NORM.
  - Else -> ROUND.
- ROUND state:
  - mant = mag[30:8], guard = mag[7], sticky = |mag[6:0]; inexact = guard | sticky.
  - Increment rule per RM_SI:
    - NEAREST: guard & (sticky | mant[0]).
    - TRUNC: never.
    - PLUSINF: inexact & ~sign.
    - MINUSINF: inexact & sign.
  - Mantissa carry-out: mant = 0 and exp + 1. Overflow is impossible for 32-bit operands.
  - Register {sign, exp, mant} and IX_SO; -> DONE.
- DONE state:
  - Valid_SO = 1. Result_DO, Zero_SO and IX_SO are registered and held stable while Ready_SI is 0.
  - Valid_SO & Ready_SI -> IDLE. The next operand cannot be accepted in the same cycle.
- Latency, counted in edges from the accept edge to Valid_SO high:
  - Zero operand: 1.
  - Non-zero operand: 3 + lz, where lz is the leading-zero count of mag (0..31). Maximum is 34.
- Flush_SI:
  - Any state -> IDLE on the next edge; Valid_SO drops and no result is produced.
  - Flush has priority over accept and over the DONE handshake.
- Reset mid-operation: immediate return to the reset values; the operand is lost.
- Zero_SO and IX_SO are meaningful only while Valid_SO is 1. They are cleared on the IDLE transition.

Optional Feature:
- Macro: FPU_ITOF_LZC_EN.
- Defined: ABS additionally computes a leading-zero count. NORM takes exactly one cycle, shifting by lz and subtracting lz from exp. Non-zero latency is fixed at 3.
- Undefined: iterative one-bit normalisation as described in Behaviour, and no LZC logic is synthesised.
- Results and flags are bit-identical in both builds.

Decomposition:
- fpu_defs package:
  - C_RM_NEAREST=2'h0, C_RM_TRUNC=2'h1, C_RM_PLUSINF=2'h2, C_RM_MINUSINF=2'h3 (existing).
  - Enum itof_state_t {IDLE, ABS, NORM, ROUND, DONE}.
  - Constant C_ITOF_EXP_INIT = C_BIAS + C_WIDTH - 1.
- Sub-module fpu_itof_round: combinational. Takes sign, exp, the normalised 32-bit magnitude and RM; returns the packed float and the inexact flag. It is reused by the LZC build.

Test Plan:
- Signed 0x00000001, NEAREST -> 0x3F800000, IX 0, Valid_SO 34 edges after accept (3 with FPU_ITOF_LZC_EN).
- Signed 0xFFFFFFFF (-1) -> 0xBF800000. Signed 0x80000000 -> 0xCF000000, IX 0, latency 3. Unsigned 0x80000000 -> 0x4F000000.
- Operand 0 (either signedness) -> Result 0x00000000, Zero_SO 1, IX 0, latency 1.
- Signed 0x7FFFFFFF:
  - NEAREST -> 0x4F000000, IX 1.
  - TRUNC -> 0x4EFFFFFF, IX 1.
  - Unsigned 0x01000001, NEAREST -> 0x4B800000, IX 1 (tie to even).
- Signed 0xFFFFFF7F (-129, exact):
  - All modes -> 0xC3010000, IX 0.
  - Signed 0x7FFFFFC1: PLUSINF -> 0x4F000000; MINUSINF -> 0x4EFFFFFF.
- Handshake and flush:
  - Hold Ready_SI 0 for 5 cycles in DONE -> outputs stable, Ready_SO 0.
  - Assert Flush_SI during NORM -> no Valid_SO; Ready_SO 1 the cycle after.
  - Assert Rst_RI mid-ROUND -> all outputs 0 immediately.
